// File: rtl/axis_pkt_pkg.sv
// rtl/axis_pkt_pkg.sv - shared types and pointer helper for the packet FIFO
package axis_pkt_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, DROP} wr_state_t;

  localparam int PTR_W = 32;

  // Distance between two wrap-bit pointers of width aw+1, valid for any aw < PTR_W
  function automatic logic [PTR_W-1:0] ptr_diff(input logic [PTR_W-1:0] a,
                                                input logic [PTR_W-1:0] b,
                                                input int unsigned aw);
    return (a - b) & ((PTR_W'(1) << (aw + 1)) - PTR_W'(1));
  endfunction

endpackage

// File: rtl/axis_pkt_ram.sv
// rtl/axis_pkt_ram.sv - simple dual-port RAM with registered, resettable read port
module axis_pkt_ram #(
  parameter int W  = 9,
  parameter int DD = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DD];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The read register doubles as the FIFO output register, so it is cleared on reset
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axis_pkt_fifo.sv
// rtl/axis_pkt_fifo.sv - AXI4-Stream packet FIFO, cut-through or store-and-forward with drop
// AXIS_PKT_FIFO_STATS_EN adds frame_cnt/drop_cnt outputs.
module axis_pkt_fifo
  import axis_pkt_pkg::*;
#(
  parameter int DW         = 8,
  parameter int DD         = 2048,
  parameter int FRAME_MODE = 1,
  localparam int AW        = $clog2(DD)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s_tdata,
  input  logic          s_tvalid,
  input  logic          s_tlast,
  input  logic          s_tuser,
  output logic          s_tready,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  output logic          m_tlast,
  input  logic          m_tready,
  output logic [AW:0]   fill_level,
`ifdef AXIS_PKT_FIFO_STATS_EN
  output logic [31:0]   frame_cnt,
  output logic [31:0]   drop_cnt,
`endif
  output logic          drop_pulse
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0] wr_ptr, cm_ptr, fetch_ptr, rd_ptr;
  wr_state_t   state;
  logic        full, acc, fetch, wr_en;
  logic [DW:0] rd_word;

  // fetch_ptr runs one ahead of rd_ptr while a beat sits in the output register
  assign rd_ptr     = fetch_ptr - {{AW{1'b0}}, m_tvalid};
  assign full       = ptr_diff(PTR_W'(wr_ptr), PTR_W'(rd_ptr), AW) == PTR_W'(DD);
  assign fill_level = (AW+1)'(ptr_diff(PTR_W'(cm_ptr), PTR_W'(rd_ptr), AW));

  assign s_tready = !rst && ((FRAME_MODE != 0 && state == DROP) || !full);
  assign acc      = s_tvalid && s_tready;
  assign wr_en    = acc && (FRAME_MODE == 0 || state != DROP);
  assign fetch    = (fetch_ptr != cm_ptr) && (!m_tvalid || m_tready);

  assign m_tlast = rd_word[DW];
  assign m_tdata = rd_word[DW-1:0];

  axis_pkt_ram #(.W(DW + 1), .DD(DD), .AW(AW)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata ({s_tlast, s_tdata}),
    .re    (fetch),
    .raddr (fetch_ptr[AW-1:0]),
    .rdata (rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      cm_ptr     <= '0;
      fetch_ptr  <= '0;
      m_tvalid   <= 1'b0;
      state      <= IDLE;
      drop_pulse <= 1'b0;
`ifdef AXIS_PKT_FIFO_STATS_EN
      frame_cnt  <= '0;
      drop_cnt   <= '0;
`endif
    end else begin
      drop_pulse <= 1'b0;

      if (fetch) begin
        fetch_ptr <= fetch_ptr + PTR_ONE;
        m_tvalid  <= 1'b1;
      end else if (m_tready) begin
        m_tvalid  <= 1'b0;
      end

      if (FRAME_MODE == 0) begin
        if (acc) begin
          wr_ptr <= wr_ptr + PTR_ONE;
          cm_ptr <= wr_ptr + PTR_ONE;
`ifdef AXIS_PKT_FIFO_STATS_EN
          if (s_tlast) frame_cnt <= frame_cnt + 32'd1;
`endif
        end
      end else begin
        case (state)
          IDLE, WRITE: begin
            if (acc) begin
              if (!s_tlast) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                state  <= WRITE;
              end else if (s_tuser) begin
                wr_ptr     <= cm_ptr;
                drop_pulse <= 1'b1;
                state      <= IDLE;
`ifdef AXIS_PKT_FIFO_STATS_EN
                drop_cnt   <= drop_cnt + 32'd1;
`endif
              end else begin
                wr_ptr <= wr_ptr + PTR_ONE;
                cm_ptr <= wr_ptr + PTR_ONE;
                state  <= IDLE;
`ifdef AXIS_PKT_FIFO_STATS_EN
                frame_cnt <= frame_cnt + 32'd1;
`endif
              end
            end else if (state == WRITE && s_tvalid && full) begin
              // Frame cannot fit behind committed data: abandon it and sink the rest
              wr_ptr <= cm_ptr;
              state  <= DROP;
            end
          end
          DROP: begin
            if (acc && s_tlast) begin
              drop_pulse <= 1'b1;
              state      <= IDLE;
`ifdef AXIS_PKT_FIFO_STATS_EN
              drop_cnt   <= drop_cnt + 32'd1;
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// tb/tb_axis_pkt_fifo.sv - scoreboard bench for axis_pkt_fifo in cut-through and frame modes
module tb_axis_pkt_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tlast = 1'b0;
  logic       s_tuser = 1'b0;
  logic       ct_v = 1'b0;
  logic       sf_v = 1'b0;
  logic       m_rdy = 1'b1;

  logic       ct_s_tready, ct_m_tvalid, ct_m_tlast, ct_drop;
  logic [7:0] ct_m_tdata;
  logic [4:0] ct_fill;
  logic       sf_s_tready, sf_m_tvalid, sf_m_tlast, sf_drop;
  logic [7:0] sf_m_tdata;
  logic [4:0] sf_fill;
`ifdef AXIS_PKT_FIFO_STATS_EN
  logic [31:0] ct_fcnt, ct_dcnt, sf_fcnt, sf_dcnt;
`endif

  int total = 0;
  int bad = 0;
  int sf_drops = 0;
  logic [8:0] exp_ct[$];
  logic [8:0] exp_sf[$];
  logic       ct_stall = 1'b0, sf_stall = 1'b0;
  logic [8:0] ct_hold = '0, sf_hold = '0;

  always #5 clk = ~clk;

  axis_pkt_fifo #(.DW(8), .DD(16), .FRAME_MODE(0)) u_ct (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(ct_v), .s_tlast(s_tlast),
    .s_tuser(s_tuser), .s_tready(ct_s_tready), .m_tdata(ct_m_tdata), .m_tvalid(ct_m_tvalid),
    .m_tlast(ct_m_tlast), .m_tready(m_rdy), .fill_level(ct_fill),
`ifdef AXIS_PKT_FIFO_STATS_EN
    .frame_cnt(ct_fcnt), .drop_cnt(ct_dcnt),
`endif
    .drop_pulse(ct_drop)
  );

  axis_pkt_fifo #(.DW(8), .DD(16), .FRAME_MODE(1)) u_sf (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(sf_v), .s_tlast(s_tlast),
    .s_tuser(s_tuser), .s_tready(sf_s_tready), .m_tdata(sf_m_tdata), .m_tvalid(sf_m_tvalid),
    .m_tlast(sf_m_tlast), .m_tready(m_rdy), .fill_level(sf_fill),
`ifdef AXIS_PKT_FIFO_STATS_EN
    .frame_cnt(sf_fcnt), .drop_cnt(sf_dcnt),
`endif
    .drop_pulse(sf_drop)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitors: pop the scoreboard on every egress handshake, and hold data steady under stall
  always @(negedge clk) begin
    if (rst) begin
      ct_stall <= 1'b0;
      sf_stall <= 1'b0;
    end else begin
      if (ct_stall) begin
        check("ct_stall_valid", 32'(ct_m_tvalid), 32'd1);
        check("ct_stall_data", 32'({ct_m_tlast, ct_m_tdata}), 32'(ct_hold));
      end
      if (sf_stall) begin
        check("sf_stall_valid", 32'(sf_m_tvalid), 32'd1);
        check("sf_stall_data", 32'({sf_m_tlast, sf_m_tdata}), 32'(sf_hold));
      end
      if (ct_m_tvalid && m_rdy) begin
        if (exp_ct.size() == 0) begin
          total++; bad++;
          $display("FAIL ct_unexpected actual=%0h required=none", {ct_m_tlast, ct_m_tdata});
        end else check("ct_beat", 32'({ct_m_tlast, ct_m_tdata}), 32'(exp_ct.pop_front()));
      end
      if (sf_m_tvalid && m_rdy) begin
        if (exp_sf.size() == 0) begin
          total++; bad++;
          $display("FAIL sf_unexpected actual=%0h required=none", {sf_m_tlast, sf_m_tdata});
        end else check("sf_beat", 32'({sf_m_tlast, sf_m_tdata}), 32'(exp_sf.pop_front()));
      end
      if (sf_drop) sf_drops <= sf_drops + 1;
      ct_stall <= ct_m_tvalid && !m_rdy;
      sf_stall <= sf_m_tvalid && !m_rdy;
      ct_hold  <= {ct_m_tlast, ct_m_tdata};
      sf_hold  <= {sf_m_tlast, sf_m_tdata};
    end
  end

  task automatic send(input bit sel, input logic [7:0] d, input logic l, input logic u);
    bit acc;
    int n;
    @(negedge clk);
    s_tdata = d; s_tlast = l; s_tuser = u;
    if (sel) sf_v = 1'b1; else ct_v = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 100) begin
      #1 acc = sel ? sf_s_tready : ct_s_tready;
      @(posedge clk);
      if (!acc) begin
        @(negedge clk);
        n++;
      end
    end
    if (!acc) begin
      total++; bad++;
      $display("FAIL send_timeout actual=%0h required=accepted", d);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    ct_v = 1'b0; sf_v = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 m_rdy = r;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] base, input int len,
                            input logic user, input bit push);
    for (int i = 0; i < len; i++) begin
      logic [7:0] d;
      logic       l;
      d = base + 8'(i);
      l = (i == len - 1);
      if (push) begin
        if (sel) exp_sf.push_back({l, d}); else exp_ct.push_back({l, d});
      end
      send(sel, d, l, user && l);
    end
    idle();
  endtask

  task automatic drain(input bit sel, input string name);
    int n;
    n = 0;
    while ((sel ? exp_sf.size() : exp_ct.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_left"}, sel ? exp_sf.size() : exp_ct.size(), 0);
    @(negedge clk);
    @(negedge clk);
    check({name, "_fill"}, 32'(sel ? sf_fill : ct_fill), 0);
    check({name, "_valid"}, 32'(sel ? sf_m_tvalid : ct_m_tvalid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_ct_ready", 32'(ct_s_tready), 0);
    check("rst_sf_ready", 32'(sf_s_tready), 0);
    check("rst_sf_outs", 32'({sf_m_tvalid, sf_m_tlast, sf_m_tdata, sf_fill, sf_drop}), 0);
    check("rst_ct_outs", 32'({ct_m_tvalid, ct_m_tlast, ct_m_tdata, ct_fill, ct_drop}), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ct_ready", 32'(ct_s_tready), 1);
    check("post_rst_sf_ready", 32'(sf_s_tready), 1);

    // Cut-through: 20 beats 0x00..0x13, first valid one cycle after first acceptance
    exp_ct.push_back({1'b0, 8'h00});
    send(1'b0, 8'h00, 1'b0, 1'b0);
    idle();
    check("ct_lat_k", 32'(ct_m_tvalid), 0);
    @(negedge clk);
    check("ct_lat_k1", 32'(ct_m_tvalid), 1);
    send_frame(1'b0, 8'h01, 19, 1'b0, 1'b1);
    drain(1'b0, "ct");
    check("ct_no_drop", 32'(ct_drop), 0);

    // Store-and-forward: nothing visible until the tlast edge
    for (int i = 0; i < 5; i++) begin
      exp_sf.push_back({i == 4, 8'hA0 + 8'(i)});
      send(1'b1, 8'hA0 + 8'(i), i == 4, 1'b0);
      if (i == 3) begin
        #1 check("sf_hold_back", 32'(sf_m_tvalid), 0);
      end
    end
    idle();
    check("sf_commit_fill", 32'(sf_fill), 5);
    check("sf_commit_valid", 32'(sf_m_tvalid), 0);
    @(negedge clk);
    check("sf_first_valid", 32'(sf_m_tvalid), 1);
    drain(1'b1, "sf");

    // Bad frame dropped, good frame passes
    send_frame(1'b1, 8'h51, 4, 1'b1, 1'b0);
    check("bad_pulse", 32'(sf_drop), 1);
    exp_sf.push_back({1'b0, 8'h11});
    send(1'b1, 8'h11, 1'b0, 1'b0);
    exp_sf.push_back({1'b1, 8'h22});
    send(1'b1, 8'h22, 1'b1, 1'b0);
    idle();
    drain(1'b1, "good_after_bad");
    check("bad_drops", 32'(sf_drops), 1);

    // Oversize: 20-beat frame with egress stalled
    set_ready(1'b0);
    send_frame(1'b1, 8'h00, 20, 1'b0, 1'b0);
    check("over_pulse", 32'(sf_drop), 1);
    check("over_fill", 32'(sf_fill), 0);
    @(negedge clk);
    @(negedge clk);
    check("over_nothing", 32'(sf_m_tvalid), 0);
    check("over_drops", 32'(sf_drops), 2);

    // Backpressure: 5 + 5 committed, third (7-beat) frame fills the FIFO and is dropped
    send_frame(1'b1, 8'h30, 5, 1'b0, 1'b1);
    send_frame(1'b1, 8'h40, 5, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) send(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
    idle();
    check("full_ready", 32'(sf_s_tready), 0);
    check("full_fill", 32'(sf_fill), 10);
    send(1'b1, 8'h56, 1'b1, 1'b0);
    idle();
    check("full_pulse", 32'(sf_drop), 1);
    check("full_fill_after", 32'(sf_fill), 10);
    repeat (3) @(negedge clk);
    set_ready(1'b1);
    drain(1'b1, "full");
    check("full_drops", 32'(sf_drops), 3);

    // Reset mid-frame, then a clean frame
    for (int i = 0; i < 3; i++) send(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
    idle();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_outs", 32'({sf_m_tvalid, sf_m_tlast, sf_m_tdata, sf_fill, sf_drop}), 0);
    check("mid_rst_ready", 32'(sf_s_tready), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ready1", 32'(sf_s_tready), 1);
    send_frame(1'b1, 8'h71, 4, 1'b0, 1'b1);
    drain(1'b1, "after_rst");
    check("after_rst_drops", 32'(sf_drops), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
